calc_sequencer: RTL and testbench

Keypad-driven sequencer for the calculator datapath. It accumulates decimal operand A, latches a one-hot operation (add/sub/mul/div), and accumulates operand B. On equals it launches the ALU with a start/done handshake and captures the result. It sits between the key decoder and the ALU, replacing free-running latch logic with a clocked FSM that has a timeout and divide-by-zero guard.

---
 rtl/calc_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | calc_sequencer : keypad-to-ALU sequencer with timeout and /0 guard    |
// | Optional macro CALC_CHAIN_EN: op key in S_RES chains the result into  |
// | operand A.                                                            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module calc_sequencer #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 digit_valid,
   input  logic [3:0]           digit,
   input  logic [3:0]           op_key,
   input  logic                 eq_key,
   input  logic                 clr_key,
   input  logic                 alu_done,
   input  logic [2*WIDTH-1:0]   alu_result,
   output logic [WIDTH-1:0]     operand_a,
   output logic [WIDTH-1:0]     operand_b,
   output logic [3:0]           op_sel,
   output logic                 alu_start,
   output logic [2*WIDTH-1:0]   result,
   output logic                 result_valid,
   output logic                 error,
   output logic                 busy
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [WIDTH+3:0] TEN = (WIDTH + 4)'(10);
   localparam logic [3:0]       OP_DIV = 4'b1000;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_OP   = 3'd1,
      S_B    = 3'd2,
      S_EXEC = 3'd3,
      S_RES  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     operand_a_q, operand_a_d;
   logic [WIDTH-1:0]     operand_b_q, operand_b_d;
   logic [3:0]           op_sel_q, op_sel_d;
   logic                 alu_start_q, alu_start_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 result_valid_q, result_valid_d;
   logic                 error_q, error_d;
   logic                 busy_q, busy_d;

   logic                 op_valid, digit_ok;
   logic                 key_eq, key_op, key_dig;
   logic [WIDTH+3:0]     acc_a, acc_b;
   logic                 acc_a_fits, acc_b_fits;

   // One key event per cycle: eq beats op beats digit (clr handled above all).
   assign op_valid = (op_key == 4'b0001) || (op_key == 4'b0010) ||
                     (op_key == 4'b0100) || (op_key == 4'b1000);
   assign digit_ok = digit_valid && (digit < 4'd10);
   assign key_eq   = eq_key;
   assign key_op   = !eq_key && op_valid;
   assign key_dig  = !eq_key && !op_valid && digit_ok;

   assign acc_a      = {4'b0, operand_a_q} * TEN + {{WIDTH{1'b0}}, digit};
   assign acc_b      = {4'b0, operand_b_q} * TEN + {{WIDTH{1'b0}}, digit};
   assign acc_a_fits = (acc_a[WIDTH+3:WIDTH] == 4'd0);
   assign acc_b_fits = (acc_b[WIDTH+3:WIDTH] == 4'd0);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      operand_a_d    = operand_a_q;
      operand_b_d    = operand_b_q;
      op_sel_d       = op_sel_q;
      alu_start_d    = 1'b0;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      error_d        = error_q;

      if (clr_key) begin
         state_d        = S_A;
         cnt_d          = '0;
         operand_a_d    = '0;
         operand_b_d    = '0;
         op_sel_d       = '0;
         result_d       = '0;
         result_valid_d = 1'b0;
         error_d        = 1'b0;
      end else begin
         case (state_q)
            S_A: begin
               if (key_op) begin
                  op_sel_d = op_key;
                  state_d  = S_OP;
               end else if (key_dig && acc_a_fits) begin
                  operand_a_d = acc_a[WIDTH-1:0];
               end
            end
            S_OP: begin
               if (key_op) begin
                  op_sel_d = op_key;
               end else if (key_dig) begin
                  operand_b_d = WIDTH'(digit);
                  state_d     = S_B;
               end
            end
            S_B: begin
               if (key_eq) begin
                  if (op_sel_q == OP_DIV && operand_b_q == '0) begin
                     error_d        = 1'b1;
                     result_d       = '0;
                     result_valid_d = 1'b0;
                     state_d        = S_RES;
                  end else begin
                     alu_start_d = 1'b1;
                     cnt_d       = '0;
                     state_d     = S_EXEC;
                  end
               end else if (key_dig && acc_b_fits) begin
                  operand_b_d = acc_b[WIDTH-1:0];
               end
            end
            S_EXEC: begin
               // A done on the timeout edge still wins over the timeout.
               if (alu_done) begin
                  result_d       = alu_result;
                  result_valid_d = 1'b1;
                  state_d        = S_RES;
               end else if (cnt_q == CW'(TIMEOUT)) begin
                  error_d        = 1'b1;
                  result_valid_d = 1'b0;
                  state_d        = S_RES;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_RES: begin
               if (key_op) begin
`ifdef CALC_CHAIN_EN
                  if (result_valid_q && result_q[2*WIDTH-1:WIDTH] == '0) begin
                     operand_a_d    = result_q[WIDTH-1:0];
                     op_sel_d       = op_key;
                     result_valid_d = 1'b0;
                     state_d        = S_OP;
                  end
`else
                  state_d = S_RES;
`endif
               end else if (key_dig) begin
                  operand_a_d    = WIDTH'(digit);
                  operand_b_d    = '0;
                  op_sel_d       = '0;
                  result_d       = '0;
                  result_valid_d = 1'b0;
                  error_d        = 1'b0;
                  state_d        = S_A;
               end
            end
            default: state_d = S_A;
         endcase
      end
   end

   assign busy_d = (state_d == S_EXEC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_A;
         cnt_q          <= '0;
         operand_a_q    <= '0;
         operand_b_q    <= '0;
         op_sel_q       <= '0;
         alu_start_q    <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         error_q        <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         operand_a_q    <= operand_a_d;
         operand_b_q    <= operand_b_d;
         op_sel_q       <= op_sel_d;
         alu_start_q    <= alu_start_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         error_q        <= error_d;
         busy_q         <= busy_d;
      end
   end

   assign operand_a    = operand_a_q;
   assign operand_b    = operand_b_q;
   assign op_sel       = op_sel_q;
   assign alu_start    = alu_start_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign error        = error_q;
   assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// Scoreboarded random bench for calc_sequencer; a keypad/ALU reference model
// predicts every output each cycle and a monitor compares after each edge.
module tb_calc_sequencer;

   localparam int W  = 8;
   localparam int TO = 8;

   localparam int MS_A = 0, MS_OP = 1, MS_B = 2, MS_EXEC = 3, MS_RES = 4;

   typedef struct packed {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [3:0]     op;
      logic           start;
      logic [2*W-1:0] res;
      logic           rv;
      logic           err;
      logic           busy;
   } snap_t;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           digit_valid = 1'b0;
   logic [3:0]     digit = 4'd0;
   logic [3:0]     op_key = 4'd0;
   logic           eq_key = 1'b0;
   logic           clr_key = 1'b0;
   logic           alu_done = 1'b0;
   logic [2*W-1:0] alu_result = '0;
   logic [W-1:0]   operand_a, operand_b;
   logic [3:0]     op_sel;
   logic           alu_start, result_valid, error, busy;
   logic [2*W-1:0] result;

   calc_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
      .op_key(op_key), .eq_key(eq_key), .clr_key(clr_key),
      .alu_done(alu_done), .alu_result(alu_result),
      .operand_a(operand_a), .operand_b(operand_b), .op_sel(op_sel),
      .alu_start(alu_start), .result(result), .result_valid(result_valid),
      .error(error), .busy(busy)
   );

   always #5 clk = ~clk;

   int    vectors = 0;
   int    miscompares = 0;
   snap_t exp_q[$];

   // Reference model state
   int             m_st = MS_A;
   logic [W-1:0]   m_a = '0, m_b = '0;
   logic [3:0]     m_op = '0;
   logic [2*W-1:0] m_res = '0;
   bit             m_rv = 0, m_err = 0, m_start = 0;
   int             m_exec_edges = 0;

   function automatic snap_t dut_snap();
      snap_t s;
      s = '{a: operand_a, b: operand_b, op: op_sel, start: alu_start,
            res: result, rv: result_valid, err: error, busy: busy};
      return s;
   endfunction

   function automatic snap_t model_snap();
      snap_t s;
      s = '{a: m_a, b: m_b, op: m_op, start: m_start, res: m_res,
            rv: m_rv, err: m_err, busy: (m_st == MS_EXEC)};
      return s;
   endfunction

   function automatic logic [W-1:0] accum(logic [W-1:0] old, logic [3:0] d);
      int v;
      v = int'(old) * 10 + int'(d);
      return (v > (1 << W) - 1) ? old : W'(v);
   endfunction

   function automatic logic [2*W-1:0] alu_calc(logic [W-1:0] a, logic [W-1:0] b,
                                               logic [3:0] op);
      logic [2*W-1:0] xa, xb;
      xa = {{W{1'b0}}, a};
      xb = {{W{1'b0}}, b};
      case (op)
         4'b0001: return xa + xb;
         4'b0010: return xa - xb;
         4'b0100: return xa * xb;
         default: return (b == 0) ? '1 : xa / xb;
      endcase
   endfunction

   task automatic model_reset();
      m_st = MS_A; m_a = '0; m_b = '0; m_op = '0; m_res = '0;
      m_rv = 0; m_err = 0; m_start = 0; m_exec_edges = 0;
   endtask

   // Drive one cycle of inputs, advance the model across the next edge and queue the prediction.
   task automatic step(bit dv, logic [3:0] d, logic [3:0] ok, bit eq, bit clr,
                       bit done, logic [2*W-1:0] ar);
      bit is_op, is_dg;
      @(negedge clk);
      digit_valid = dv; digit = d; op_key = ok; eq_key = eq; clr_key = clr;
      alu_done = done; alu_result = ar;
      is_op = !eq && (ok == 4'b0001 || ok == 4'b0010 || ok == 4'b0100 || ok == 4'b1000);
      is_dg = !eq && !is_op && dv && (d < 10);
      m_start = 0;
      if (clr) begin
         model_reset();
      end else begin
         case (m_st)
            MS_A: if (is_op) begin m_op = ok; m_st = MS_OP; end
                  else if (is_dg) m_a = accum(m_a, d);
            MS_OP: if (is_op) m_op = ok;
                   else if (is_dg) begin m_b = W'(d); m_st = MS_B; end
            MS_B: if (eq) begin
                     if (m_op == 4'b1000 && m_b == 0) begin
                        m_err = 1; m_res = '0; m_rv = 0; m_st = MS_RES;
                     end else begin
                        m_start = 1; m_exec_edges = 0; m_st = MS_EXEC;
                     end
                  end else if (is_dg) m_b = accum(m_b, d);
            MS_EXEC: begin
               m_exec_edges++;
               if (done) begin m_res = ar; m_rv = 1; m_st = MS_RES; end
               else if (m_exec_edges > TO) begin m_err = 1; m_rv = 0; m_st = MS_RES; end
            end
            default: begin
               if (is_op) begin
`ifdef CALC_CHAIN_EN
                  if (m_rv && m_res[2*W-1:W] == 0) begin
                     m_a = m_res[W-1:0]; m_op = ok; m_rv = 0; m_st = MS_OP;
                  end
`endif
               end else if (is_dg) begin
                  m_a = W'(d); m_b = '0; m_op = '0; m_res = '0;
                  m_rv = 0; m_err = 0; m_st = MS_A;
               end
            end
         endcase
      end
      exp_q.push_back(model_snap());
   endtask

   task automatic dig(int d);   step(1, 4'(d), 4'd0, 0, 0, 0, '0); endtask
   task automatic opk(int o);   step(0, 4'd0, 4'(o), 0, 0, 0, '0); endtask
   task automatic eqk();        step(0, 4'd0, 4'd0, 1, 0, 0, '0); endtask
   task automatic clr();        step(0, 4'd0, 4'd0, 0, 1, 0, '0); endtask
   task automatic idle(int n);  for (int i = 0; i < n; i++) step(0, 4'd0, 4'd0, 0, 0, 0, '0); endtask
   task automatic done(int r);  step(0, 4'd0, 4'd0, 0, 0, 1, (2*W)'(r)); endtask

   task automatic check_zero(string name);
      snap_t g;
      g = dut_snap();
      vectors++;
      if (g !== '0) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h", name, g, snap_t'('0));
      end
   endtask

   task automatic async_reset();
      @(negedge clk);
      digit_valid = 0; op_key = '0; eq_key = 0; clr_key = 0; alu_done = 0;
      #2 reset = 1'b1;
      #1 check_zero("async_reset");
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // Monitor: compare every queued prediction just after the edge it describes.
   initial begin
      snap_t e, g;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = dut_snap();
            vectors++;
            if (g !== e) begin
               miscompares++;
               $display("FAIL snapshot t=%0t got=%h exp=%h", $time, g, e);
            end
         end
      end
   end

   initial begin
      bit             pend;
      int             acnt, adelay, r;
      bit             dv, eq, cl, dn;
      logic [3:0]     d, ok;
      logic [2*W-1:0] ar;

      repeat (2) @(negedge clk);
      check_zero("reset_state");
      reset = 1'b0;

      // Basic add, two-cycle ALU latency
      dig(1); dig(2); opk(1); dig(3); eqk(); idle(1); done(15); idle(1);
      // Overflow reject and op replacement
      clr(); dig(2); dig(5); dig(6); opk(4); opk(2); dig(4); idle(1);
      // Divide by zero
      clr(); dig(9); opk(8); dig(0); eqk(); idle(2); done(7); idle(1);
      // Timeout then late done
      clr(); dig(7); opk(1); dig(1); eqk(); idle(TO + 3); done(99); idle(1);
      // Result 15 then op key in S_RES
      clr(); dig(1); dig(0); opk(1); dig(5); eqk(); done(15); opk(2); idle(1); dig(2); eqk(); idle(1);
      // clr mid-exec
      clr(); dig(3); opk(4); dig(3); eqk(); idle(1); clr(); done(99); idle(1);
      // async reset mid-exec
      dig(3); opk(1); dig(3); eqk(); idle(1); async_reset(); done(99); idle(1);

      pend = 0; acnt = 0; adelay = 0;
      for (int i = 0; i < 4000; i++) begin
         dv = 0; d = '0; ok = '0; eq = 0; cl = 0; dn = 0; ar = '0;
         if (m_start) begin
            pend = 1; acnt = 0; adelay = $urandom_range(1, TO + 3);
         end
         if (pend) begin
            acnt++;
            if (acnt == adelay) begin
               dn = 1; pend = 0;
               ar = ($urandom_range(0, 4) == 0) ? (2*W)'($urandom) : alu_calc(m_a, m_b, m_op);
            end
         end else if ($urandom_range(0, 49) == 0) begin
            dn = 1; ar = (2*W)'($urandom);
         end
         r = $urandom_range(0, 99);
         if (r < 2) cl = 1;
         else if (r < 14) eq = 1;
         else if (r < 30) ok = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
         else if (r < 70) begin dv = 1; d = 4'($urandom_range(0, 11)); end
         step(dv, d, ok, eq, cl, dn, ar);
      end
      idle(2);
      repeat (2) @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
